// File: rtl/bus_width_responder_if.sv
// Request/memory bundle for bus_width_responder.
// The slave side is the responder itself. The master side is whatever drives
// requests and models the external memory.
interface bus_width_responder_if #(
    parameter int AW = 24
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [1:0]    mem_width;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_be;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata;
    logic          mem_rdy;
    logic          ack;
    logic [63:0]   rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_width,
               mem_rdata, mem_rdy,
        output req_ready, mem_cs, mem_we, mem_addr, mem_be, mem_wdata, ack, rdata
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_width,
               mem_rdata, mem_rdy,
        input  req_ready, mem_cs, mem_we, mem_addr, mem_be, mem_wdata, ack, rdata
    );
endinterface

// File: rtl/bus_width_responder.sv
// Memory-side responder: splits 8/16/32/64-bit right-justified transfers into
// beats on a memory port whose width is chosen at run time. Ordering is
// big-endian: beat 0 carries the most-significant piece, and byte offset o of
// a memory word sits on lane Wb-1-o.
module bus_width_responder #(
    parameter int AW       = 24,
    parameter int MIN_WAIT = 1
) (
    input logic               sys_clk,
    input logic               reset,
    bus_width_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] WAIT_RELOAD = 8'(MIN_WAIT - 1);

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    width_q, width_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    beats_q, beats_d;     // beats remaining after the current one
    logic [7:0]    wait_q, wait_d;
    logic [63:0]   acc_q, acc_d;         // read assembly, shifts left one beat at a time
    logic [63:0]   wbuf_q, wbuf_d;       // write data, left-justified, consumed from the top
    logic [63:0]   rdata_q, rdata_d;

    // Geometry of the latched transfer
    logic [6:0]    w_bits, s_bits, req_bits;
    logic [3:0]    wb_bytes, sb_bytes, offset, lane_lo;
    logic [6:0]    lane_sh;
    logic [63:0]   mask_w, mask_s;
    logic          narrow, beat_done;
    logic [63:0]   acc_shifted, narrow_rd;
    logic [7:0]    be_wide, be_narrow;
    logic [AW-1:0] req_align_mask;

    assign w_bits      = 7'd8 << width_q;
    assign s_bits      = 7'd8 << size_q;
    assign req_bits    = 7'd8 << bus.req_size;
    assign wb_bytes    = 4'd1 << width_q;
    assign sb_bytes    = 4'd1 << size_q;
    assign narrow      = (size_q < width_q);
    assign offset      = {1'b0, addr_q[2:0]} & (wb_bytes - 4'd1);
    // Lowest lane of a narrow item; only meaningful when narrow=1
    assign lane_lo     = wb_bytes - offset - sb_bytes;
    assign lane_sh     = {lane_lo, 3'b000};
    // A shift by 64 yields 0, so these become all-ones for 64-bit widths
    assign mask_w      = (64'd1 << w_bits) - 64'd1;
    assign mask_s      = (64'd1 << s_bits) - 64'd1;
    assign beat_done   = (state_q == ACCESS) && (wait_q == '0) && bus.mem_rdy;
    assign acc_shifted = (acc_q << w_bits) | (bus.mem_rdata & mask_w);
    assign narrow_rd   = (bus.mem_rdata >> lane_sh) & mask_s;
    assign be_wide     = 8'((9'd1 << wb_bytes) - 9'd1);
    assign be_narrow   = 8'(((9'd1 << sb_bytes) - 9'd1) << lane_lo);
    assign req_align_mask = AW'((4'd1 << bus.req_size) - 4'd1);

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            width_q <= 2'd0;
            addr_q  <= '0;
            beats_q <= 3'd0;
            wait_q  <= 8'd0;
            acc_q   <= 64'd0;
            wbuf_q  <= 64'd0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            wait_q  <= wait_d;
            acc_q   <= acc_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: accept, beat sequencing, completion
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        width_d = width_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        wait_d  = wait_q;
        acc_d   = acc_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = ACCESS;
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    width_d = bus.mem_width;
                    addr_d  = bus.req_addr & ~req_align_mask;
                    wait_d  = WAIT_RELOAD;
                    acc_d   = 64'd0;
                    wbuf_d  = bus.req_wdata << (7'd64 - req_bits);
                    beats_d = (bus.req_size > bus.mem_width)
                            ? 3'((4'd1 << (bus.req_size - bus.mem_width)) - 4'd1)
                            : 3'd0;
                end
            end
            ACCESS: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 8'd1;
                end
                if (beat_done) begin
                    acc_d  = acc_shifted;
                    wbuf_d = wbuf_q << w_bits;
                    if (beats_q != 3'd0) begin
                        beats_d = beats_q - 3'd1;
                        addr_d  = addr_q + AW'(wb_bytes);
                        wait_d  = WAIT_RELOAD;
                    end else begin
                        state_d = DONE;
                        rdata_d = write_q ? 64'd0 : (narrow ? narrow_rd : acc_shifted);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory lanes are only driven during ACCESS
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_cs    = (state_q == ACCESS);
        bus.mem_we    = (state_q == ACCESS) && write_q;
        bus.mem_addr  = addr_q;
        bus.mem_be    = 8'd0;
        bus.mem_wdata = 64'd0;
        bus.ack       = (state_q == DONE);
        bus.rdata     = rdata_q;
        if (state_q == ACCESS) begin
            if (narrow) begin
                bus.mem_be    = be_narrow;
                bus.mem_wdata = (wbuf_q >> (7'd64 - s_bits)) << lane_sh;
            end else begin
                bus.mem_be    = be_wide;
                bus.mem_wdata = wbuf_q >> (7'd64 - w_bits);
            end
        end
    end
endmodule

// File: tb/tb_bus_width_responder.sv
// Bench for bus_width_responder: a vector table on a MIN_WAIT=1 instance plus
// hand sequences for wait stretching (MIN_WAIT=3 instance) and mid-transfer reset.
module tb_bus_width_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst2;

    bus_width_responder_if #(.AW(24)) b1 ();
    bus_width_responder_if #(.AW(24)) b2 ();

    bus_width_responder #(.AW(24), .MIN_WAIT(1)) dut1 (
        .sys_clk(clk), .reset(rst1), .bus(b1.slave));
    bus_width_responder #(.AW(24), .MIN_WAIT(3)) dut2 (
        .sys_clk(clk), .reset(rst2), .bus(b2.slave));

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [1:0]  width;
        logic [23:0] addr;
        logic [63:0] wdata;
        logic [511:0] rbeats;   // beat i read data at [i*64 +: 64]
        int          n;
        logic [23:0] addr0;
        logic [7:0]  be0;       // single-beat writes
        logic [63:0] wd0;       // single-beat writes, low W bits
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        int          n;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [511:0] rb1(input logic [63:0] b0);
        return {448'h0, b0};
    endfunction

    function automatic logic [511:0] rb2(input logic [63:0] b0, input logic [63:0] b1v);
        return {384'h0, b1v, b0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop_check(input string name, input logic [63:0] act_rdata, input int act_n);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s: ack with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " rdata"}, act_rdata, e.rdata);
            if (act_n >= 0) check({name, " beats"}, 64'(act_n), 64'(e.n));
        end
    endtask

    task automatic run_vec(input int k);
        vec_t        v;
        exp_t        e;
        int          beat;
        bit          got_ack;
        logic [6:0]  w;
        logic [3:0]  wb;
        logic [63:0] mw, piece;
        logic [7:0]  ebe;
        logic [23:0] ea;
        string       nm;
        v  = vecs[k];
        nm = $sformatf("v%0d", k);
        w  = 7'd8 << v.width;
        wb = 4'd1 << v.width;
        mw = (64'd1 << w) - 64'd1;
        @(negedge clk);
        check({nm, " req_ready"}, 64'(b1.req_ready), 64'd1);
        b1.req_valid = 1'b1;
        b1.req_write = v.wr;
        b1.req_size  = v.size;
        b1.req_addr  = v.addr;
        b1.req_wdata = v.wdata;
        b1.mem_width = v.width;
        b1.mem_rdy   = 1'b1;
        e.rdata = v.exp_rdata;
        e.n     = v.n;
        sb_q.push_back(e);
        beat    = 0;
        got_ack = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_ack; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                // post-accept changes must be ignored
                b1.req_valid = 1'b0;
                b1.req_write = ~v.wr;
                b1.req_size  = ~v.size;
                b1.req_addr  = 24'hABCDEF;
                b1.req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
                b1.mem_width = ~v.width;
            end
            if (b1.mem_cs) begin
                if (beat < 8) b1.mem_rdata = v.rbeats[beat*64 +: 64];
                ea = v.addr0 + 24'(beat) * 24'(wb);
                check($sformatf("%s b%0d addr", nm, beat), 64'(b1.mem_addr), 64'(ea));
                check($sformatf("%s b%0d we", nm, beat), 64'(b1.mem_we), 64'(v.wr));
                if (v.wr) begin
                    piece = (v.n == 1) ? v.wd0 : ((v.wdata >> ((v.n - 1 - beat) * w)) & mw);
                    ebe   = (v.n == 1) ? v.be0 : 8'((9'd1 << wb) - 9'd1);
                    check($sformatf("%s b%0d wdata", nm, beat), b1.mem_wdata & mw, piece);
                    check($sformatf("%s b%0d be", nm, beat), 64'(b1.mem_be), 64'(ebe));
                end
                beat++;
            end
            if (b1.ack) begin
                got_ack = 1'b1;
                check({nm, " latency"}, 64'(cyc), 64'(v.n));
                check({nm, " ready@ack"}, 64'(b1.req_ready), 64'd0);
                sb_pop_check(nm, b1.rdata, beat);
                $display("[TB] txn %s %s size=%0d width=%0d addr=%h beats=%0d rdata=%h",
                         nm, v.wr ? "WR" : "RD", v.size, v.width, v.addr, beat, b1.rdata);
            end
        end
        if (!got_ack) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s ack timeout", nm);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
    endtask

    // MIN_WAIT=3 write with mem_rdy held low for the first 'low' beat cycles
    task automatic run_t5(input int low, input int exp_cs);
        exp_t  e;
        int    cs_cnt;
        int    acks;
        string nm;
        nm = $sformatf("t5_low%0d", low);
        @(negedge clk);
        b2.req_valid = 1'b1;
        b2.req_write = 1'b1;
        b2.req_size  = 2'd3;
        b2.mem_width = 2'd3;
        b2.req_addr  = 24'h000080;
        b2.req_wdata = 64'hFEDCBA9876543210;
        b2.mem_rdy   = 1'b0;
        e.rdata = 64'd0;
        e.n     = 1;
        sb_q.push_back(e);
        cs_cnt = 0;
        acks   = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc == 0) b2.req_valid = 1'b0;
            if (b2.mem_cs) begin
                check({nm, " addr"}, 64'(b2.mem_addr), 64'h80);
                check({nm, " we"}, 64'(b2.mem_we), 64'd1);
                check({nm, " be"}, 64'(b2.mem_be), 64'hFF);
                check({nm, " wdata"}, b2.mem_wdata, 64'hFEDCBA9876543210);
                b2.mem_rdy = (cs_cnt >= low);
                cs_cnt++;
            end else begin
                b2.mem_rdy = 1'b1;   // must be ignored outside a beat
            end
            if (b2.ack) begin
                acks++;
                sb_pop_check(nm, b2.rdata, -1);
            end
        end
        check({nm, " cs cycles"}, 64'(cs_cnt), 64'(exp_cs));
        check({nm, " ack count"}, 64'(acks), 64'd1);
        $display("[TB] txn %s WR beat_cycles=%0d acks=%0d", nm, cs_cnt, acks);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, " req_ready"}, 64'(b1.req_ready), 64'd1);
        check({nm, " mem_cs"}, 64'(b1.mem_cs), 64'd0);
        check({nm, " mem_we"}, 64'(b1.mem_we), 64'd0);
        check({nm, " ack"}, 64'(b1.ack), 64'd0);
        check({nm, " mem_be"}, 64'(b1.mem_be), 64'd0);
        check({nm, " mem_addr"}, 64'(b1.mem_addr), 64'd0);
        check({nm, " mem_wdata"}, b1.mem_wdata, 64'd0);
        check({nm, " rdata"}, b1.rdata, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        vecs[0] = '{1'b0, 2'd3, 2'd3, 24'h000100, 64'h0, rb1(64'h0123456789ABCDEF),
                    1, 24'h000100, 8'hFF, 64'h0, 64'h0123456789ABCDEF};
        vecs[1] = '{1'b0, 2'd2, 2'd1, 24'h000200, 64'h0, rb2(64'h1234, 64'h5678),
                    2, 24'h000200, 8'h00, 64'h0, 64'h12345678};
        vecs[2] = '{1'b1, 2'd3, 2'd0, 24'h000010, 64'h1122334455667788, 512'h0,
                    8, 24'h000010, 8'h01, 64'h0, 64'h0};
        vecs[3] = '{1'b1, 2'd0, 2'd2, 24'h000005, 64'h123456789ABCDEAB, 512'h0,
                    1, 24'h000005, 8'h04, 64'h00AB0000, 64'h0};
        vecs[4] = '{1'b0, 2'd0, 2'd2, 24'h000005, 64'h0, rb1(64'h11AB2233),
                    1, 24'h000005, 8'h00, 64'h0, 64'hAB};
        vecs[5] = '{1'b0, 2'd1, 2'd3, 24'h000007, 64'h0, rb1(64'hFFEEDDCCBBAA9988),
                    1, 24'h000006, 8'h00, 64'h0, 64'h9988};
        vecs[6] = '{1'b1, 2'd2, 2'd1, 24'h000301, 64'h00000000DEADBEEF, 512'h0,
                    2, 24'h000300, 8'h03, 64'h0, 64'h0};
        vecs[7] = '{1'b0, 2'd3, 2'd2, 24'h000040, 64'h0, rb2(64'hA1B2C3D4, 64'h55667788),
                    2, 24'h000040, 8'h00, 64'h0, 64'hA1B2C3D455667788};
        vecs[8] = '{1'b0, 2'd2, 2'd3, 24'h000000, 64'h0, rb1(64'hCAFEF00D12345678),
                    1, 24'h000000, 8'h00, 64'h0, 64'hCAFEF00D};
        vecs[9] = '{1'b1, 2'd1, 2'd3, 24'h000002, 64'h00000000FFFFBEEF, 512'h0,
                    1, 24'h000002, 8'h30, 64'h0000BEEF00000000, 64'h0};

        rst1 = 1'b1;
        rst2 = 1'b1;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_size = 2'd0; b1.req_addr = '0;
        b1.req_wdata = '0;   b1.mem_width = 2'd0; b1.mem_rdata = '0;  b1.mem_rdy = 1'b1;
        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_size = 2'd0; b2.req_addr = '0;
        b2.req_wdata = '0;   b2.mem_width = 2'd0; b2.mem_rdata = '0;  b2.mem_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        rst2 = 1'b0;
        check_reset_vals("reset");

        for (int k = 0; k < 10; k++) run_vec(k);

        // Reset during beat 1 of a 4-beat read
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_size = 2'd3;
        b1.mem_width = 2'd1; b1.req_addr = 24'h000500; b1.mem_rdy = 1'b1;
        b1.mem_rdata = 64'h1111;
        @(negedge clk);
        b1.req_valid = 1'b0;
        check("t6 beat0 cs", 64'(b1.mem_cs), 64'd1);
        @(negedge clk);
        check("t6 beat1 cs", 64'(b1.mem_cs), 64'd1);
        check("t6 beat1 addr", 64'(b1.mem_addr), 64'h502);
        rst1 = 1'b1;
        @(negedge clk);
        check_reset_vals("t6 after reset");
        rst1 = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (b1.ack) acks++;
        end
        check("t6 no ack", 64'(acks), 64'd0);
        $display("[TB] txn t6 RD aborted by reset acks=%0d", acks);
        run_vec(1);

        run_t5(5, 6);
        run_t5(1, 3);
        run_t5(0, 3);

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
